reg_dump_streamer: RTL and testbench
====================================

# reg_dump_streamer

Debug read-out stage directly downstream of the register file's debug read port. On a start request it walks register indices 0..NUM_REGS-1 via the debug select, samples each value, and emits a framed byte stream (header byte, then each register MSB-first) over a valid/ready handshake into the UART transmitter. This gives the host a full architectural register dump without halting the core.

## Interface
- WIDTH, 32, register width in bits; must be a multiple of 8
- NUM_REGS, 32, number of registers dumped; index width is clog2(NUM_REGS), 5 at default
- HEADER_BYTE, 8'hA5, frame start byte sent before register data
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (low = reset asserted)
- start  input  1  dump request; sampled only in IDLE
- Debug_Source_select  output  5  register index driven to the register file debug port
- Debug_out  input  WIDTH  combinational debug read data returned by the register file
- tx_data  output  8  byte to UART transmitter
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  UART transmitter accepts byte; transfer occurs when tx_valid & tx_ready
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse when the final byte has been accepted

## Operation
- FSM states: IDLE, HEADER, LOAD, SEND, FINISH.
- IDLE: tx_valid=0, busy=0. On start=1: idx<=0, go to HEADER. start is ignored in every other state; no queuing.
- HEADER: tx_valid=1, tx_data=HEADER_BYTE. On handshake -> LOAD.
- LOAD: tx_valid=0. Debug_Source_select=idx is already stable. At cycle end shift_reg<=Debug_out, byte_cnt<=0 -> SEND.
- SEND: tx_valid=1, tx_data=shift_reg[WIDTH-1:WIDTH-8].
  - On handshake with byte_cnt<WIDTH/8-1: shift_reg<<=8, byte_cnt++.
  - On handshake with byte_cnt==WIDTH/8-1: if idx==NUM_REGS-1 -> FINISH; else idx++ -> LOAD.
- FINISH: done=1 for this cycle only, tx_valid=0 -> IDLE.
- Debug_Source_select is driven directly from the registered idx. It holds its last value in IDLE.
- Each register is sampled independently in its LOAD cycle. The dump is not an atomic snapshot: writes by the running core between LOAD cycles are visible. Register 0 always reads 0.
- Frame length: 1 + NUM_REGS*WIDTH/8 bytes, which is 129 at default.

## Timing
- Reset values: tx_valid=0, tx_data=8'h00, busy=0, done=0, Debug_Source_select=0, state=IDLE, byte_cnt=0, shift_reg=0.
- Reset takes effect immediately, including mid-frame. The frame is abandoned with no done pulse, and tx_valid drops asynchronously.
- start high on cycle 0 -> HEADER byte valid on cycle 1.
- Per register: 1 LOAD cycle + WIDTH/8 SEND cycles (5 cycles at default when tx_ready=1).
- Full dump with tx_ready held at 1: header on cycle 1, last byte accepted on cycle 161, done on cycle 162, busy high on cycles 1..162, IDLE on cycle 163.
- Handshake: while tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable. tx_valid never drops without a transfer, except on reset.
- tx_ready is don't-care while tx_valid=0 (LOAD, FINISH, IDLE).
- start held continuously triggers a new frame on the cycle after FINISH returns to IDLE (cycle 163 -> header on cycle 164).

## Structure
- Shared debug package holds the state enum (IDLE, HEADER, LOAD, SEND, FINISH) and the default HEADER_BYTE constant, for reuse by the host-side command decoder.
- No sub-module: the FSM, index counter, byte counter and shift register are written inline in one module of roughly 150 lines.

## Test plan
- Register file preloaded with x[i]=32'h1000_0000+i, tx_ready=1, start pulse -> 129 bytes: A5, 00 00 00 00 (x0), 10 00 00 01, …, 10 00 00 1F; done pulses on cycle 162.
- tx_ready random at 30% duty -> identical byte sequence; tx_data stays stable on every stalled cycle; exactly one done pulse.
- start pulsed again mid-frame (cycle 50) -> ignored; the frame is unchanged and no second header appears.
- reset asserted at byte 60 -> tx_valid=0 and busy=0 immediately, no done pulse; a following start produces a complete fresh frame beginning with A5.
- x5 written from 32'h0 to 32'hDEAD_BEEF during x3's SEND phase -> x5 bytes are DE AD BE EF (sampled at its own LOAD).
- start held high -> back-to-back frames; second header appears on cycle 164.

Source files
------------

// File: rtl/reg_dump_streamer_pkg.sv
// Shared debug definitions: dump-streamer FSM states and the default frame
// header byte. The host-side command decoder imports the same package.
package reg_dump_streamer_pkg;

  localparam int unsigned BYTE_W = 8;

  // Byte that opens every register dump frame.
  localparam logic [BYTE_W-1:0] DEFAULT_HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    LOAD   = 3'd2,
    SEND   = 3'd3,
    FINISH = 3'd4
  } state_e;

endpackage : reg_dump_streamer_pkg

// File: rtl/reg_dump_streamer.sv
// Register dump streamer: on start, walks register indices 0..NUM_REGS-1
// through the register file debug port and emits a byte frame
// (HEADER_BYTE, then each register MSB-first) over a valid/ready handshake.
//
// Ports:
//   clk                 system clock
//   reset               asynchronous active-low reset
//   start               dump request, sampled only in IDLE
//   Debug_Source_select register index to the register file debug port
//   Debug_out           combinational debug read data for that index
//   tx_data / tx_valid  byte stream to the UART transmitter
//   tx_ready            transmitter accepts the current byte
//   busy                high whenever the FSM is not IDLE
//   done                one-cycle pulse after the final byte is accepted
module reg_dump_streamer
  import reg_dump_streamer_pkg::*;
#(
  parameter int unsigned       WIDTH       = 32,
  parameter int unsigned       NUM_REGS    = 32,
  parameter logic [BYTE_W-1:0] HEADER_BYTE = DEFAULT_HEADER_BYTE,
  localparam int unsigned      IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [IDX_W-1:0]  Debug_Source_select,
  input  logic [WIDTH-1:0]  Debug_out,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NUM_BYTES = WIDTH / BYTE_W;
  localparam int unsigned CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);

  // Register width must split into whole bytes.
  if ((WIDTH % BYTE_W) != 0 || WIDTH < BYTE_W) begin : g_bad_width
    $error("reg_dump_streamer: WIDTH must be a non-zero multiple of 8");
  end

  state_e              state_q,    state_d;
  logic [IDX_W-1:0]    idx_q,      idx_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [WIDTH-1:0]    shift_q,    shift_d;
  logic [BYTE_W-1:0]   tx_data_q,  tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic                xfer;

  assign xfer = tx_valid_q & tx_ready;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state, index/byte counters and shift register.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (xfer) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Debug_Source_select has held idx for this whole cycle.
        shift_d = Debug_out;
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (cnt_q == LAST_BYTE) begin
            if (idx_q == LAST_IDX) begin
              state_d = FINISH;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = LOAD;
            end
          end else begin
            shift_d = shift_q << BYTE_W;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs are computed from the next state so they line up
  // with the state they describe. A stalled byte keeps shift_d unchanged,
  // so tx_data holds.
  always_comb begin
    tx_valid_d = (state_d == HEADER) || (state_d == SEND);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FINISH);
    tx_data_d  = tx_data_q;
    if (state_d == HEADER) begin
      tx_data_d = HEADER_BYTE;
    end else if (state_d == SEND) begin
      tx_data_d = shift_d[WIDTH-1 -: BYTE_W];
    end
  end

  assign Debug_Source_select = idx_q;
  assign tx_data             = tx_data_q;
  assign tx_valid            = tx_valid_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule : reg_dump_streamer

// File: tb/tb_reg_dump_streamer.sv
// Self-checking bench for reg_dump_streamer: a register-file model drives
// Debug_out, expected frame bytes are queued when a dump is started and
// popped as bytes are accepted, plus table-driven cycle checks.
module tb_reg_dump_streamer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  Debug_Source_select;
  logic [31:0] Debug_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic [31:0] regs     [32];
  logic [31:0] exp_regs [32];
  logic [7:0]  exp_q [$];

  int n_tests;
  int n_fail;
  int done_cnt;
  int frame_bytes;
  int ready_pct;

  logic       prev_stall;
  logic [7:0] prev_data;

  typedef struct {
    int         cyc;
    logic       exp_valid;
    logic       exp_busy;
    logic       exp_done;
    logic [4:0] exp_sel;
    logic       chk_data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [12];

  reg_dump_streamer dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .Debug_Source_select (Debug_Source_select),
    .Debug_out           (Debug_out),
    .tx_data             (tx_data),
    .tx_valid            (tx_valid),
    .tx_ready            (tx_ready),
    .busy                (busy),
    .done                (done)
  );

  assign Debug_out = regs[Debug_Source_select];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ready driver: changes just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (ready_pct >= 100) tx_ready = 1'b1;
    else                  tx_ready = ($urandom_range(0, 99) < ready_pct);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          check("frame_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        frame_bytes++;
      end
      if (done) done_cnt++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic push_frame();
    exp_q.push_back(8'hA5);
    for (int r = 0; r < 32; r++) begin
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(exp_regs[r][b*8 +: 8]);
      end
    end
  endtask

  task automatic wait_done(input int max_cycles);
    int  base;
    bit  seen;
    base = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (done_cnt > base) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    done_cnt   = 0;
    frame_bytes = 0;
    ready_pct  = 100;
    tx_ready   = 1'b1;
    start      = 1'b0;
    reset      = 1'b0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    for (int i = 0; i < 32; i++) begin
      regs[i]     = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
      exp_regs[i] = regs[i];
    end

    //             cyc  vld  busy done sel  chk  data
    tbl[0]  = '{  0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 8'h00};
    tbl[1]  = '{  1,  1'b1, 1'b1, 1'b0, 5'd0,  1'b1, 8'hA5};
    tbl[2]  = '{  2,  1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 8'h00};
    tbl[3]  = '{  3,  1'b1, 1'b1, 1'b0, 5'd0,  1'b1, 8'h00};
    tbl[4]  = '{  7,  1'b0, 1'b1, 1'b0, 5'd1,  1'b0, 8'h00};
    tbl[5]  = '{  8,  1'b1, 1'b1, 1'b0, 5'd1,  1'b1, 8'h10};
    tbl[6]  = '{ 11,  1'b1, 1'b1, 1'b0, 5'd1,  1'b1, 8'h01};
    tbl[7]  = '{157,  1'b0, 1'b1, 1'b0, 5'd31, 1'b0, 8'h00};
    tbl[8]  = '{158,  1'b1, 1'b1, 1'b0, 5'd31, 1'b1, 8'h10};
    tbl[9]  = '{161,  1'b1, 1'b1, 1'b0, 5'd31, 1'b1, 8'h1F};
    tbl[10] = '{162,  1'b0, 1'b1, 1'b1, 5'd31, 1'b0, 8'h00};
    tbl[11] = '{163,  1'b0, 1'b0, 1'b0, 5'd31, 1'b0, 8'h00};

    // Reset state, held in reset then just after release.
    repeat (2) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sel", 32'(Debug_Source_select), 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_tx_valid", 32'(tx_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Full dump, tx_ready=1, cycle-accurate table.
    begin
      int vi;
      vi = 0;
      done_cnt = 0;
      push_frame();
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k <= 163; k++) begin
        if (k > 0) @(negedge clk);
        if (k == 1) start = 1'b0;
        while (vi < 12 && tbl[vi].cyc == k) begin
          check($sformatf("tbl%0d_valid", tbl[vi].cyc), 32'(tx_valid), 32'(tbl[vi].exp_valid));
          check($sformatf("tbl%0d_busy", tbl[vi].cyc), 32'(busy), 32'(tbl[vi].exp_busy));
          check($sformatf("tbl%0d_done", tbl[vi].cyc), 32'(done), 32'(tbl[vi].exp_done));
          check($sformatf("tbl%0d_sel", tbl[vi].cyc), 32'(Debug_Source_select), 32'(tbl[vi].exp_sel));
          if (tbl[vi].chk_data)
            check($sformatf("tbl%0d_data", tbl[vi].cyc), 32'(tx_data), 32'(tbl[vi].exp_data));
          vi++;
        end
      end
      check("full_done_cnt", 32'(done_cnt), 32'd1);
      check("full_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // Random 30% ready: same bytes, stable stalls, one done.
    ready_pct = 30;
    done_cnt = 0;
    push_frame();
    pulse_start();
    wait_done(3000);
    repeat (20) @(negedge clk);
    ready_pct = 100;
    check("rand_done_cnt", 32'(done_cnt), 32'd1);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    // Start re-pulsed mid-frame is ignored.
    done_cnt = 0;
    push_frame();
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 163; k++) begin
      @(negedge clk);
      if (k == 1)  start = 1'b0;
      if (k == 50) start = 1'b1;
      if (k == 51) start = 1'b0;
      if (k == 162) check("mid_done_162", 32'(done), 32'd1);
      if (k == 163) check("mid_busy_163", 32'(busy), 32'd0);
    end
    repeat (10) @(negedge clk);
    check("mid_no_refire_busy", 32'(busy), 32'd0);
    check("mid_no_refire_valid", 32'(tx_valid), 32'd0);
    check("mid_done_cnt", 32'(done_cnt), 32'd1);
    check("mid_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset at byte 60: immediate drop, no done, then a fresh full frame.
    begin
      bit reached;
      reached = 1'b0;
      done_cnt = 0;
      frame_bytes = 0;
      push_frame();
      pulse_start();
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (frame_bytes >= 60) begin
          reached = 1'b1;
          break;
        end
      end
      check("rst60_reached", 32'(reached), 32'd1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("rst60_tx_valid", 32'(tx_valid), 32'd0);
      check("rst60_busy", 32'(busy), 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      check("rst60_no_done", 32'(done_cnt), 32'd0);
      @(posedge clk);
      #2 reset = 1'b1;
      frame_bytes = 0;
      push_frame();
      pulse_start();
      wait_done(500);
      check("rst60_fresh_bytes", 32'(frame_bytes), 32'd129);
      check("rst60_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // x5 rewritten during x3's SEND phase appears in the dump.
    regs[5]     = 32'h0;
    exp_regs[5] = 32'hDEAD_BEEF;
    done_cnt = 0;
    push_frame();
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 163; k++) begin
      @(negedge clk);
      if (k == 1)  start = 1'b0;
      if (k == 19) begin
        check("x5_sel_in_x3_send", 32'(Debug_Source_select), 32'd3);
        regs[5] = 32'hDEAD_BEEF;
      end
      if (k == 162) check("x5_done_162", 32'(done), 32'd1);
    end
    check("x5_queue_empty", 32'(exp_q.size()), 32'd0);
    regs[5]     = 32'h1000_0005;
    exp_regs[5] = 32'h1000_0005;
    repeat (2) @(negedge clk);

    // start held high: back-to-back frames, second header on cycle 164.
    done_cnt = 0;
    push_frame();
    push_frame();
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 170; k++) begin
      @(negedge clk);
      if (k == 162) check("held_done_162", 32'(done), 32'd1);
      if (k == 163) begin
        check("held_valid_163", 32'(tx_valid), 32'd0);
        check("held_busy_163", 32'(busy), 32'd0);
      end
      if (k == 164) begin
        check("held_valid_164", 32'(tx_valid), 32'd1);
        check("held_hdr_164", 32'(tx_data), 32'hA5);
      end
    end
    start = 1'b0;
    wait_done(500);
    repeat (5) @(negedge clk);
    check("held_done_cnt", 32'(done_cnt), 32'd2);
    check("held_queue_empty", 32'(exp_q.size()), 32'd0);
    check("held_final_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_reg_dump_streamer
